jk_reg_bank: RTL and testbench

- Parametrised WIDTH-bit bank of JK flip-flops with shared clock, enable and synchronous reset.
- Adds counter modes: the same bank counts up or down using JK toggle semantics, or parallel-loads.
- Used as a general state/flag register and as a small counter in control datapaths.
- Q_n is always the exact complement of Q in the same cycle; there is no one-cycle lag.

---
 rtl/jk_reg_bank.sv | 139 +++++++++++++
 tb/tb_jk_reg_bank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-bit bank of JK flip-flops with shared clock enable,
// synchronous reset, JK / count-up / count-down / parallel-load modes.
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RST        synchronous reset, active-high, highest priority
//   EN         clock enable; when low Q holds and WRAP clears
//   MODE[1:0]  00 JK, 01 count up, 10 count down, 11 parallel load
//   J, K       per-bit JK inputs (MODE 00 only)
//   D          parallel load data (MODE 11 only)
//   Q, Q_n     registered state and its combinational complement
//   TC         terminal count (combinational, independent of EN)
//   WRAP       registered one-cycle pulse on a counter wrap
//
// Optional build macro JK_REG_BANK_SAT_EN: count modes saturate at their
// limit instead of wrapping; WRAP then pulses on a count attempted at the
// limit and Q is left unchanged on that edge.

module jk_reg_bank #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_n,
    output logic             TC,
    output logic             WRAP
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DN   = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;

    logic [WIDTH-1:0] up_t;
    logic [WIDTH-1:0] dn_t;
    logic [WIDTH-1:0] j_eff;
    logic [WIDTH-1:0] k_eff;
    logic [WIDTH-1:0] q_nxt;
    logic             all_ones;
    logic             all_zero;
    logic             tc_c;

    // Toggle enables for a synchronous JK counter: bit i toggles when
    // every lower bit is 1 (up) or every lower bit is 0 (down).
    always_comb begin
        logic lo_ones;
        logic lo_zero;
        lo_ones = 1'b1;
        lo_zero = 1'b1;
        up_t    = '0;
        dn_t    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i] = lo_ones;
            dn_t[i] = lo_zero;
            lo_ones = lo_ones & q_r[i];
            lo_zero = lo_zero & ~q_r[i];
        end
    end

    assign all_ones = &q_r;
    assign all_zero = ~|q_r;

    always_comb begin
        tc_c = 1'b0;
        case (MODE)
            MODE_UP: tc_c = all_ones;
            MODE_DN: tc_c = all_zero;
            default: tc_c = 1'b0;
        endcase
    end

    // Every mode is expressed as J/K drive into the same flop equation;
    // a load is J=D, K=~D.
    always_comb begin
        j_eff = '0;
        k_eff = '0;
        case (MODE)
            MODE_JK: begin
                j_eff = J;
                k_eff = K;
            end
            MODE_UP: begin
                j_eff = up_t;
                k_eff = up_t;
            end
            MODE_DN: begin
                j_eff = dn_t;
                k_eff = dn_t;
            end
            MODE_LOAD: begin
                j_eff = D;
                k_eff = ~D;
            end
            default: begin
                j_eff = '0;
                k_eff = '0;
            end
        endcase
`ifdef JK_REG_BANK_SAT_EN
        // At the limit the counter holds instead of wrapping.
        if (tc_c) begin
            j_eff = '0;
            k_eff = '0;
        end
`endif
    end

    assign q_nxt = (j_eff & ~q_r) | (~k_eff & q_r);

    // The wrap (or saturating-attempt) event is an enabled edge where
    // the count mode sits at its terminal value.
    always_ff @(posedge CLK) begin
        if (RST) begin
            q_r    <= RESET_VAL;
            wrap_r <= 1'b0;
        end else if (EN) begin
            q_r    <= q_nxt;
            wrap_r <= tc_c;
        end else begin
            wrap_r <= 1'b0;
        end
    end

    assign Q    = q_r;
    assign Q_n  = ~q_r;
    assign TC   = tc_c;
    assign WRAP = wrap_r;

endmodule

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank: directed vector table, hand sequences and randomized
// stimulus against a behavioural model for jk_reg_bank (WIDTH=8).

module tb_jk_reg_bank;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;
`ifdef JK_REG_BANK_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic         EN;
    logic [1:0]   MODE;
    logic [W-1:0] J;
    logic [W-1:0] K;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic [W-1:0] Q_n;
    logic         TC;
    logic         WRAP;

    int checks = 0;
    int errors = 0;

    jk_reg_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE),
        .J(J), .K(K), .D(D),
        .Q(Q), .Q_n(Q_n), .TC(TC), .WRAP(WRAP)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic [7:0] j;
        logic [7:0] k;
        logic [7:0] d;
        logic [7:0] eq;
        logic       ewrap;
        logic       etc;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic [7:0] jj, input logic [7:0] kk,
                         input logic [7:0] dd);
        RST = r; EN = e; MODE = m; J = jj; K = kk; D = dd;
    endtask

    task automatic edge1();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: state as an integer, rules taken straight from the
    // JK truth table and modular counting.
    int unsigned m_q;
    bit          m_wrap;

    function automatic bit m_tc(input logic [1:0] m, input int unsigned q);
        return (m == 2'b01 && q == 255) || (m == 2'b10 && q == 0);
    endfunction

    task automatic m_step();
        int unsigned nq;
        bit at_lim;
        at_lim = m_tc(MODE, m_q);
        if (RST) begin
            m_q = RV; m_wrap = 0;
        end else if (!EN) begin
            m_wrap = 0;
        end else begin
            nq = m_q;
            m_wrap = 0;
            case (MODE)
                2'b00: begin
                    nq = 0;
                    for (int b = 0; b < 8; b++) begin
                        bit qb, jb, kb, r;
                        qb = m_q[b]; jb = J[b]; kb = K[b];
                        if (!jb && !kb) r = qb;
                        else if (!jb && kb) r = 0;
                        else if (jb && !kb) r = 1;
                        else r = !qb;
                        nq[b] = r;
                    end
                end
                2'b01: begin
                    nq = (SAT && at_lim) ? m_q : (m_q + 1) % 256;
                    m_wrap = at_lim;
                end
                2'b10: begin
                    nq = (SAT && at_lim) ? m_q : (m_q + 255) % 256;
                    m_wrap = at_lim;
                end
                default: nq = D;
            endcase
            m_q = nq;
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 2'b00, 8'h00, 8'h00, 8'h00);

        tbl[0]  = '{1, 0, 2'b01, 8'h00, 8'h00, 8'h00, RV, 0, 0};
        tbl[1]  = '{0, 0, 2'b01, 8'h00, 8'h00, 8'h00, RV, 0, 0};
        tbl[2]  = '{0, 0, 2'b01, 8'h00, 8'h00, 8'h00, RV, 0, 0};
        tbl[3]  = '{0, 0, 2'b01, 8'h00, 8'h00, 8'h00, RV, 0, 0};
        tbl[4]  = '{0, 1, 2'b11, 8'h00, 8'h00, 8'hF0, 8'hF0, 0, 0};
        tbl[5]  = '{0, 1, 2'b00, 8'hCC, 8'hAA, 8'h00, 8'h5C, 0, 0};
        tbl[6]  = '{0, 1, 2'b11, 8'h00, 8'h00, 8'hFE, 8'hFE, 0, 0};
        tbl[7]  = '{0, 1, 2'b01, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 1};
        tbl[8]  = '{0, 1, 2'b01, 8'h00, 8'h00, 8'h00,
                    SAT ? 8'hFF : 8'h00, 1, SAT};
        tbl[9]  = '{0, 1, 2'b01, 8'h00, 8'h00, 8'h00,
                    SAT ? 8'hFF : 8'h01, SAT, SAT};
        tbl[10] = '{0, 1, 2'b11, 8'h00, 8'h00, 8'h01, 8'h01, 0, 0};
        tbl[11] = '{0, 1, 2'b10, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1};
        tbl[12] = '{0, 1, 2'b10, 8'h00, 8'h00, 8'h00,
                    SAT ? 8'h00 : 8'hFF, 1, SAT};
        tbl[13] = '{0, 1, 2'b11, 8'h00, 8'h00, 8'h7F, 8'h7F, 0, 0};
        tbl[14] = '{1, 1, 2'b01, 8'h00, 8'h00, 8'h00, RV, 0, 0};
        tbl[15] = '{0, 1, 2'b11, 8'h00, 8'h00, 8'hFF, 8'hFF, 0, 0};
        tbl[16] = '{0, 1, 2'b01, 8'h00, 8'h00, 8'h00,
                    SAT ? 8'hFF : 8'h00, 1, SAT};
        tbl[17] = '{0, 1, 2'b10, 8'h00, 8'h00, 8'h00,
                    SAT ? 8'hFE : 8'hFF, !SAT, 0};
        tbl[18] = '{0, 1, 2'b00, 8'hFF, 8'h00, 8'h00, 8'hFF, 0, 0};

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].mode,
                  tbl[i].j, tbl[i].k, tbl[i].d);
            edge1();
            chk($sformatf("vec%0d Q", i), Q, tbl[i].eq);
            chk($sformatf("vec%0d Q_n", i), Q_n, ~tbl[i].eq & 8'hFF);
            chk($sformatf("vec%0d WRAP", i), WRAP, tbl[i].ewrap);
            chk($sformatf("vec%0d TC", i), TC, tbl[i].etc);
        end

        // TC ignores EN; a WRAP pulse survives a mode change.
        drive(0, 1, 2'b11, 8'h00, 8'h00, 8'hFF);
        edge1();
        drive(0, 0, 2'b01, 8'h00, 8'h00, 8'h00);
        #1;
        chk("tc_en0", TC, 1);
        drive(0, 1, 2'b01, 8'h00, 8'h00, 8'h00);
        edge1();
        drive(0, 1, 2'b11, 8'h00, 8'h00, 8'h33);
        #1;
        chk("wrap_after_mode_chg", WRAP, 1);
        chk("tc_load_mode", TC, 0);
        edge1();
        chk("load_after_wrap Q", Q, 8'h33);
        chk("load_after_wrap WRAP", WRAP, 0);

        // EN low clears a pending wrap pulse.
        drive(0, 1, 2'b10, 8'h00, 8'h00, 8'h00);
        edge1();
        drive(0, 1, 2'b11, 8'h00, 8'h00, 8'h00);
        edge1();
        drive(0, 1, 2'b10, 8'h00, 8'h00, 8'h00);
        edge1();
        chk("dn_wrap WRAP", WRAP, 1);
        chk("dn_wrap Q", Q, SAT ? 8'h00 : 8'hFF);
        drive(0, 0, 2'b10, 8'h00, 8'h00, 8'h00);
        edge1();
        chk("en0_clr WRAP", WRAP, 0);
        chk("en0_hold Q", Q, SAT ? 8'h00 : 8'hFF);

        // Randomized run against the model.
        drive(1, 1, 2'b00, 8'h00, 8'h00, 8'h00);
        edge1();
        m_q = RV; m_wrap = 0;
        for (int n = 0; n < 400; n++) begin
            logic [1:0] mm;
            mm = 2'($urandom_range(0, 3));
            // Bias toward counting and near-limit loads to hit wraps.
            if ($urandom_range(0, 2) != 0) mm = 2'($urandom_range(1, 2));
            drive($urandom_range(0, 40) == 0, $urandom_range(0, 7) != 0, mm,
                  8'($urandom), 8'($urandom),
                  ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 2)) :
                  8'($urandom_range(253, 255)));
            m_step();
            edge1();
            chk($sformatf("rnd%0d Q", n), Q, m_q);
            chk($sformatf("rnd%0d Q_n", n), Q_n, ~m_q & 32'hFF);
            chk($sformatf("rnd%0d WRAP", n), WRAP, m_wrap);
            chk($sformatf("rnd%0d TC", n), TC, m_tc(MODE, m_q));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
